sub8bit_seq: RTL and testbench
==============================

# sub8bit_seq

Bit-serial inverse of the 8-bit ripple-carry adder: given a 9-bit sum and one 8-bit operand, recovers the other operand (a = sum − b) one bit per clock through a single full-subtractor cell. It sits beside the adder as its checker/decoder stage, consuming the adder's 9-bit result format directly, and reports when the sum cannot have come from an 8-bit adder with that operand.

## Interface
- W, 8, operand width in bits; sum is W+1 bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  request; sampled only in IDLE
- sum  in  W+1  adder result to invert; captured on accepted start
- b  in  W  known operand; captured on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse; a and err valid
- a  out  W  recovered operand; held between done pulses
- err  out  1  sum not representable as a+b with 8-bit a; held with a

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 latches sum into shift register s_r, b into b_r. Clears borrow, bit counter cnt=0 and result shift register a_r. Moves to SHIFT.
- SHIFT: each cycle the full-subtractor takes s_r[0], b_r[0] and borrow.
  - d = s^b^bin; bout = (~s&b) | (~(s^b)&bin).
  - d shifts into a_r MSB; s_r and b_r shift right; borrow<=bout; cnt++.
  - After W cycles (cnt==W−1 on the last cycle), moves to DONE.
- DONE: evaluates the top bit. Valid iff s_r[0] (original sum[W]) == borrow.
  - sum[W]=0, borrow=1: underflow (sum<b), err=1.
  - sum[W]=1, borrow=0: overflow (sum>b+2^W−1), err=1.
  - Drives a/err registers, pulses done, returns to IDLE.
- start is ignored in SHIFT and DONE; no queuing.
- Arithmetic is unsigned only; no signed interpretation.

## Timing
- Reset values: busy=0, done=0, a=0, err=0, state IDLE, all internal registers 0.
- start sampled high at edge t: busy=1 from t through t+W (W cycles). done=1 for exactly the cycle after t+W, i.e. W+1 cycles after acceptance.
- a and err update on the edge that raises done. They are stable until the next done.
- Back-to-back: earliest next accepted start is the cycle after done; throughput is one result per W+2 cycles.
- rst_n low at any edge, including mid-SHIFT: returns to IDLE on that edge, no done pulse, a/err cleared to 0.
- rst_n has priority over start in the same cycle.

## Configuration
- SUB8_SAT_EN defined: on err, a saturates. Underflow gives a=0; overflow gives a={W{1}}.
- SUB8_SAT_EN undefined: on err, a = low W bits of the raw difference (wrap-around).
- err is identical in both builds.

## Structure
- Shared package sub8_pkg holds the state enum (IDLE/SHIFT/DONE), default width constant SUB8_W=8, and counter width $clog2(W).
- One sub-module, fs: combinational full-subtractor (s, b, bin -> d, bout), instantiated once.
- The top is FSM, counter and shift registers only.

## Test plan
- sum=140, b=20 -> after 9 cycles done=1, a=120, err=0; busy high exactly 8 cycles.
- sum=355, b=100 -> a=255, err=0; all 10 adder testbench pairs round-trip (e.g. sum=300, b=150 -> a=150).
- sum=100, b=120 (underflow) -> err=1; a=0 with SUB8_SAT_EN, a=236 without.
- sum=511, b=0 (overflow) -> err=1, a=255 in both builds.
- start pulsed at cycles 3 and 5 after an accepted start -> ignored, single done, result of first operands only.
- rst_n low at cycle 4 of SHIFT -> busy=0 next edge, no done, a=0, err=0; new start then completes normally.

Source files
------------

// File: rtl/sub8_pkg.sv
// Shared definitions for the bit-serial subtractor (sub8bit_seq): width default and FSM encoding.
// Optional feature macro used by the top: SUB8_SAT_EN (saturate a on err).
package sub8_pkg;

    localparam int SUB8_W     = 8;
    localparam int SUB8_CNT_W = $clog2(SUB8_W);

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/sub8bit_seq_fs.sv
// Combinational full-subtractor cell: d = s - b - bin, with borrow-out.
module fs (
    input  logic s,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = s ^ b ^ bin;
    assign bout = (~s & b) | (~(s ^ b) & bin);

endmodule

// File: rtl/sub8bit_seq.sv
// Bit-serial inverse of the ripple-carry adder: recovers a = sum - b one bit per clock.
// Build option: define SUB8_SAT_EN to saturate a on err (underflow -> 0, overflow -> all ones).
module sub8bit_seq
    import sub8_pkg::*;
#(
    parameter int W = SUB8_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W:0]   sum,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] a,
    output logic         err,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(W);

    // Handshake: start is taken only in IDLE (no queuing); busy is high for the W
    // shifting cycles; done pulses one cycle with a/err valid, which then hold.

    state_t         state;
    logic [W:0]     s_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   a_r;
    logic           borrow;
    logic [CW-1:0]  cnt;
    logic           d;
    logic           bout;
    logic           underflow;
    logic           overflow;

    fs u_fs (
        .s    (s_r[0]),
        .b    (b_r[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    // After W shifts s_r[0] holds sum[W]; it must match the final borrow.
    assign underflow = ~s_r[0] & borrow;
    assign overflow  = s_r[0] & ~borrow;

    assign busy      = (state == SHIFT);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            s_r    <= '0;
            b_r    <= '0;
            a_r    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            a      <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_r    <= sum;
                        b_r    <= b;
                        a_r    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_r    <= {d, a_r[W-1:1]};
                    s_r    <= {1'b0, s_r[W:1]};
                    b_r    <= {1'b0, b_r[W-1:1]};
                    borrow <= bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    err  <= underflow | overflow;
`ifdef SUB8_SAT_EN
                    if (underflow) begin
                        a <= '0;
                    end else if (overflow) begin
                        a <= '1;
                    end else begin
                        a <= a_r;
                    end
`else
                    a <= a_r;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub8bit_seq.sv
// Self-checking bench for sub8bit_seq: vector table, corner sequences, randomized ops vs. arithmetic model.
module tb_sub8bit_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W:0]   sum;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] a;
    logic         err;
    logic [1:0]   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W:0]   sum;
        logic [W-1:0] b;
        logic [W-1:0] a;
        logic         err;
    } vec_t;

    vec_t vecs[13];

`ifdef SUB8_SAT_EN
    localparam logic [W-1:0] A_100_120 = 8'd0;
    localparam logic [W-1:0] A_256_0   = 8'd255;
    localparam logic [W-1:0] A_0_1     = 8'd0;
`else
    localparam logic [W-1:0] A_100_120 = 8'd236;
    localparam logic [W-1:0] A_256_0   = 8'd0;
    localparam logic [W-1:0] A_0_1     = 8'd255;
`endif

    sub8bit_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sum       (sum),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .a         (a),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer subtraction, {err, a}
    function automatic logic [W:0] model(input logic [W:0] s, input logic [W-1:0] bv);
        int           diff;
        logic         e;
        logic [W-1:0] r;
        diff = int'(s) - int'(bv);
        e    = (diff < 0) || (diff > 255);
        r    = W'(diff);
`ifdef SUB8_SAT_EN
        if (diff < 0) r = '0;
        else if (diff > 255) r = '1;
`endif
        return {e, r};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: called #1 after a posedge. With chain=1 it returns on the done
    // sample so the next call's start lands in the done cycle (back-to-back).
    task automatic run_op(input logic [W:0] s, input logic [W-1:0] bv,
                          input logic [W:0] expv, input string name, input bit chain);
        logic [W:0] e;
        int         lat;
        int         busy_cnt;
        bit         seen;
        sum   = s;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat < 30) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
        e = exp_q.pop_front();
        check({name, "_done_seen"}, int'(seen), 1);
        check({name, "_latency"}, lat, W + 1);
        check({name, "_busy_cycles"}, busy_cnt, W);
        check({name, "_a"}, int'(a), int'(e[W-1:0]));
        check({name, "_err"}, int'(err), int'(e[W]));
        if (!chain) begin
            @(posedge clk); #1;
            check({name, "_done_pulse"}, int'(done), 0);
            check({name, "_a_hold"}, int'(a), int'(e[W-1:0]));
        end
    endtask

    initial begin
        logic [W:0]   s;
        logic [W-1:0] bv;
        logic [W-1:0] av;
        logic [W:0]   e;
        int           dones;
        int           first;
        logic [W-1:0] a_seen;
        logic         err_seen;

        vecs[0]  = '{9'd140, 8'd20,  8'd120,    1'b0};
        vecs[1]  = '{9'd355, 8'd100, 8'd255,    1'b0};
        vecs[2]  = '{9'd300, 8'd150, 8'd150,    1'b0};
        vecs[3]  = '{9'd100, 8'd120, A_100_120, 1'b1};
        vecs[4]  = '{9'd511, 8'd0,   8'd255,    1'b1};
        vecs[5]  = '{9'd0,   8'd0,   8'd0,      1'b0};
        vecs[6]  = '{9'd255, 8'd255, 8'd0,      1'b0};
        vecs[7]  = '{9'd510, 8'd255, 8'd255,    1'b0};
        vecs[8]  = '{9'd256, 8'd0,   A_256_0,   1'b1};
        vecs[9]  = '{9'd0,   8'd1,   A_0_1,     1'b1};
        vecs[10] = '{9'd256, 8'd1,   8'd255,    1'b0};
        vecs[11] = '{9'd200, 8'd55,  8'd145,    1'b0};
        vecs[12] = '{9'd256, 8'd255, 8'd1,      1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sum   = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_a", int'(a), 0);
        check("reset_err", int'(err), 0);

        // Reset wins over start on the same edge
        start = 1'b1;
        sum   = 9'd140;
        b     = 8'd20;
        @(posedge clk); #1;
        check("rst_prio_busy", int'(busy), 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_prio_idle", int'(busy), 0);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].sum, vecs[i].b, {vecs[i].err, vecs[i].a},
                   $sformatf("vec%0d", i), (i % 3) == 1);
        end

        // Stray starts during processing are ignored
        sum   = 9'd140;
        b     = 8'd20;
        start = 1'b1;
        exp_q.push_back(model(9'd140, 8'd20));
        @(posedge clk); #1;
        dones    = 0;
        first    = -1;
        a_seen   = '0;
        err_seen = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3 || k == 5) begin
                start = 1'b1;
                sum   = 9'd511;
                b     = 8'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (first < 0) begin
                    first    = k;
                    a_seen   = a;
                    err_seen = err;
                end
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check("ignore_start_dones", dones, 1);
        check("ignore_start_latency", first, W + 1);
        check("ignore_start_a", int'(a_seen), int'(e[W-1:0]));
        check("ignore_start_err", int'(err_seen), int'(e[W]));

        // Reset in the middle of SHIFT
        sum   = 9'd300;
        b     = 8'd150;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_a", int'(a), 0);
        check("midrst_err", int'(err), 0);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_op(9'd140, 8'd20, model(9'd140, 8'd20), "after_rst", 1'b0);

        // Randomized operations, half of them built as genuine adder results
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                av = W'($urandom_range(0, 255));
                bv = W'($urandom_range(0, 255));
                s  = {1'b0, av} + {1'b0, bv};
            end else begin
                s  = (W+1)'($urandom_range(0, 511));
                bv = W'($urandom_range(0, 255));
            end
            run_op(s, bv, model(s, bv), $sformatf("rnd%0d", i),
                   ($urandom_range(0, 1) == 1) && (i != 39));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
